icache: RTL and testbench

// Direct-mapped, one-word-per-line instruction cache between the fetch stage and memory_control.

---
 rtl/icache.sv | 124 ++++++++++++
 tb/tb_icache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between fetch and memory_control.
// Define ICACHE_STATS_EN to add the hit_cnt_out / miss_cnt_out statistics outputs.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  jump_or_not_in,
    input  logic                  if_enable_in,
    input  logic [ADDR_WIDTH-1:0] if_address_in,
    output logic                  inst_valid_out,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_addr_out,
    output logic                  icache_busy_out,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [31:0]           mem_data_in,
    input  logic                  mem_done_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_out,
    output logic [31:0]           miss_cnt_out
`endif
);
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic [31:0]             data_q [LINES];
    logic                    flushPending_q;
    logic                    instValid_q;
    logic [31:0]             inst_q;
    logic [ADDR_WIDTH-1:0]   instAddr_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
`ifdef ICACHE_STATS_EN
    logic [31:0]             hitCnt_q;
    logic [31:0]             missCnt_q;
`endif

    logic [INDEX_BITS-1:0]   reqIndex;
    logic [TAG_W-1:0]        reqTag;
    logic                    lookupHit;
    logic [INDEX_BITS-1:0]   fillIndex;
    logic [TAG_W-1:0]        fillTag;

    assign reqIndex  = if_address_in[INDEX_BITS+1:2];
    assign reqTag    = if_address_in[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lookupHit = valid_q[reqIndex] && (tag_q[reqIndex] == reqTag);
    assign fillIndex = memAddr_q[INDEX_BITS+1:2];
    assign fillTag   = memAddr_q[ADDR_WIDTH-1:INDEX_BITS+2];

    // Request drops in the same cycle as the done pulse so memory_control never restarts the read.
    assign mem_req_out     = (state_q == MISS) && !mem_done_in;
    assign icache_busy_out = (state_q != IDLE);
    assign inst_valid_out  = instValid_q;
    assign inst_out        = inst_q;
    assign inst_addr_out   = instAddr_q;
    assign mem_addr_out    = memAddr_q;
`ifdef ICACHE_STATS_EN
    assign hit_cnt_out     = hitCnt_q;
    assign miss_cnt_out    = missCnt_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            flushPending_q <= 1'b0;
            instValid_q    <= 1'b0;
            inst_q         <= '0;
            instAddr_q     <= '0;
            memAddr_q      <= '0;
`ifdef ICACHE_STATS_EN
            hitCnt_q       <= '0;
            missCnt_q      <= '0;
`endif
        end else begin
            instValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_enable_in && !jump_or_not_in) begin
                        if (lookupHit) begin
                            instValid_q <= 1'b1;
                            inst_q      <= data_q[reqIndex];
                            instAddr_q  <= if_address_in;
`ifdef ICACHE_STATS_EN
                            hitCnt_q    <= hitCnt_q + 32'd1;
`endif
                        end else begin
                            memAddr_q      <= {if_address_in[ADDR_WIDTH-1:2], 2'b00};
                            flushPending_q <= 1'b0;
                            state_q        <= MISS;
`ifdef ICACHE_STATS_EN
                            missCnt_q      <= missCnt_q + 32'd1;
`endif
                        end
                    end
                end
                MISS: begin
                    // A flushed fill still installs: the word is correct for its address.
                    if (mem_done_in) begin
                        valid_q[fillIndex] <= 1'b1;
                        tag_q[fillIndex]   <= fillTag;
                        data_q[fillIndex]  <= mem_data_in;
                        state_q            <= IDLE;
                        flushPending_q     <= 1'b0;
                        if (!flushPending_q && !jump_or_not_in) begin
                            instValid_q <= 1'b1;
                            inst_q      <= mem_data_in;
                            instAddr_q  <= memAddr_q;
                        end
                    end else if (jump_or_not_in) begin
                        flushPending_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache against a line-to-address reference model.
`timescale 1ns/1ps
module tb_icache;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        jump_or_not_in;
    logic        if_enable_in;
    logic [31:0] if_address_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;
    logic        icache_busy_out;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_in;
    logic        mem_done_in;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_out;
    logic [31:0] miss_cnt_out;
`endif

    icache #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .jump_or_not_in(jump_or_not_in),
        .if_enable_in(if_enable_in),
        .if_address_in(if_address_in),
        .inst_valid_out(inst_valid_out),
        .inst_out(inst_out),
        .inst_addr_out(inst_addr_out),
        .icache_busy_out(icache_busy_out),
        .mem_req_out(mem_req_out),
        .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data_in),
        .mem_done_in(mem_done_in)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_out(hit_cnt_out),
        .miss_cnt_out(miss_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sbQueue [$];
    exp_t        monExp;
    logic [31:0] memContent [logic [31:0]];
    bit          lineValid [128];
    logic [31:0] lineAddr [128];
    int          refHits = 0;
    int          refMisses = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory image: explicit words where a test needs a specific value, otherwise a fixed hash of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (memContent.exists(a)) return memContent[a];
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // The reference cache remembers, per line index, which word address that line holds.
    function automatic bit refHit(input logic [31:0] a);
        int idx;
        idx = int'(a[8:2]);
        return lineValid[idx] && (lineAddr[idx] == a);
    endfunction

    function automatic void refReset();
        foreach (lineValid[i]) lineValid[i] = 1'b0;
        refHits   = 0;
        refMisses = 0;
    endfunction

    // Monitor: every delivered instruction must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk_in);
            if (inst_valid_out === 1'b1) begin
                if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: inst_valid_out=1 at addr 0x%08h, required no pulse", inst_addr_out);
                end else begin
                    monExp = sbQueue.pop_front();
                    checkOutput("inst_out", inst_out, monExp.data);
                    checkOutput("inst_addr_out", inst_addr_out, monExp.addr);
                end
            end
        end
    end

    // One fetch: hit or miss predicted by the model; on a miss, memory answers after lat cycles,
    // with an optional jump pulse jumpAt cycles into the wait (jumpAt == lat lands on the done cycle).
    task automatic applyStimulus(input logic [31:0] addr, input int lat, input int jumpAt);
        bit   hit;
        bit   flushed;
        int   idx;
        int   reqLow;
        exp_t e;
        idx = int'(addr[8:2]);
        hit = refHit(addr);
        e.addr = addr;
        e.data = memWord(addr);
        if_enable_in  = 1'b1;
        if_address_in = addr;
        if (hit) begin
            sbQueue.push_back(e);
            refHits++;
        end else begin
            refMisses++;
        end
        @(posedge clk_in); #1;
        if_enable_in = 1'b0;
        checkOutput("mem_req_after_request", {31'd0, mem_req_out}, hit ? 32'd0 : 32'd1);
        checkOutput("busy_after_request", {31'd0, icache_busy_out}, hit ? 32'd0 : 32'd1);
        if (!hit) begin
            checkOutput("mem_addr_out", mem_addr_out, addr);
            flushed = 1'b0;
            reqLow  = 0;
            for (int k = 0; k < lat; k++) begin
                jump_or_not_in = (k == jumpAt);
                if (k == jumpAt) flushed = 1'b1;
                @(negedge clk_in);
                if (mem_req_out !== 1'b1) reqLow++;
                @(posedge clk_in); #1;
            end
            jump_or_not_in = (jumpAt == lat);
            if (jumpAt == lat) flushed = 1'b1;
            mem_done_in = 1'b1;
            mem_data_in = e.data;
            lineValid[idx] = 1'b1;
            lineAddr[idx]  = addr;
            if (!flushed) sbQueue.push_back(e);
            @(negedge clk_in);
            checkOutput("mem_req_during_done", {31'd0, mem_req_out}, 32'd0);
            checkOutput("mem_req_low_cycles_while_waiting", reqLow, 0);
            @(posedge clk_in); #1;
            mem_done_in    = 1'b0;
            jump_or_not_in = 1'b0;
            mem_data_in    = $urandom;
            checkOutput("busy_after_fill", {31'd0, icache_busy_out}, 32'd0);
        end
        @(negedge clk_in); #1;
        checkOutput("pending_pulses", sbQueue.size(), 0);
    endtask

    // Fetch request and jump in the same IDLE cycle: the jump wins, nothing is requested or delivered.
    task automatic flushIdle(input logic [31:0] addr);
        if_enable_in   = 1'b1;
        jump_or_not_in = 1'b1;
        if_address_in  = addr;
        @(posedge clk_in); #1;
        if_enable_in   = 1'b0;
        jump_or_not_in = 1'b0;
        checkOutput("idle_flush_mem_req", {31'd0, mem_req_out}, 32'd0);
        checkOutput("idle_flush_busy", {31'd0, icache_busy_out}, 32'd0);
        @(negedge clk_in); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then randomized fetches over a small address pool to force hits and evictions.
    initial begin
        logic [31:0] addr;
        int          lat;
        int          jumpAt;
        rst_in         = 1'b1;
        jump_or_not_in = 1'b0;
        if_enable_in   = 1'b0;
        if_address_in  = '0;
        mem_data_in    = '0;
        mem_done_in    = 1'b0;
        refReset();
        memContent[32'h0000_0000] = 32'h0000_0013;
        memContent[32'h0000_0100] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checkOutput("reset_inst_valid", {31'd0, inst_valid_out}, 32'd0);
        checkOutput("reset_inst_out", inst_out, 32'd0);
        checkOutput("reset_inst_addr", inst_addr_out, 32'd0);
        checkOutput("reset_mem_addr", mem_addr_out, 32'd0);
        checkOutput("reset_mem_req", {31'd0, mem_req_out}, 32'd0);
        checkOutput("reset_busy", {31'd0, icache_busy_out}, 32'd0);
`ifdef ICACHE_STATS_EN
        checkOutput("reset_hit_cnt", hit_cnt_out, 32'd0);
        checkOutput("reset_miss_cnt", miss_cnt_out, 32'd0);
`endif

        applyStimulus(32'h0000_0000, 5, -1);
        applyStimulus(32'h0000_0000, 5, -1);
`ifdef ICACHE_STATS_EN
        checkOutput("stats_hit_after_first_pair", hit_cnt_out, 32'd1);
        checkOutput("stats_miss_after_first_pair", miss_cnt_out, 32'd1);
`endif

        applyStimulus(32'h0000_0004, 5, -1);
        applyStimulus(32'h0000_0204, 6, -1);
        applyStimulus(32'h0000_0004, 5, -1);

        applyStimulus(32'h0000_0100, 7, 3);
        applyStimulus(32'h0000_0100, 5, -1);

        applyStimulus(32'h0000_0040, 20, -1);
        applyStimulus(32'h0000_0080, 6, 6);
        applyStimulus(32'h0000_0080, 5, -1);

        flushIdle(32'h0000_0000);
        flushIdle(32'h0000_0500);

        if_enable_in  = 1'b1;
        if_address_in = 32'h0000_0400;
        @(posedge clk_in); #1;
        if_enable_in = 1'b0;
        checkOutput("miss_before_reset_req", {31'd0, mem_req_out}, 32'd1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        refReset();
        checkOutput("reset_in_miss_busy", {31'd0, icache_busy_out}, 32'd0);
        checkOutput("reset_in_miss_req", {31'd0, mem_req_out}, 32'd0);
        mem_done_in = 1'b1;
        mem_data_in = 32'hBAD0_BAD0;
        @(posedge clk_in); #1;
        mem_done_in = 1'b0;
        checkOutput("stray_done_busy", {31'd0, icache_busy_out}, 32'd0);
        @(negedge clk_in); #1;
        applyStimulus(32'h0000_0000, 5, -1);
        applyStimulus(32'h0000_0400, 5, -1);

        for (int n = 0; n < 250; n++) begin
            addr = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 127) << 2);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'h8000_0000;
            lat    = $urandom_range(5, 10);
            jumpAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
            if ($urandom_range(0, 9) == 0) flushIdle(addr);
            else applyStimulus(addr, lat, jumpAt);
        end
`ifdef ICACHE_STATS_EN
        checkOutput("stats_hit_final", hit_cnt_out, refHits);
        checkOutput("stats_miss_final", miss_cnt_out, refMisses);
`endif
        repeat (3) @(posedge clk_in);
        checkOutput("scoreboard_drained", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
